instruction_memory: RTL and testbench

- Responder side of the Microprocessor instruction-fetch interface: takes the 8-bit `instruction_address` (PC) and returns the 8-bit `instruction`.
- Holds a small writable program store.
- Load mode: the user keys bytes in from board switches, one debounced push-button strobe per byte.
- Run mode: the store serves fetches. It sits between board I/O and the processor core, on the free-running oscillator.

---
 rtl/microprocessor_pkg.sv | 20 ++
 rtl/instruction_memory_strobe_debouncer.sv | 57 +++++
 rtl/instruction_memory.sv | 112 +++++++++++
 tb/tb_instruction_memory.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/microprocessor_pkg.sv
// Shared definitions for the microprocessor board: opcodes, the HALT
// instruction and the program-store load FSM state encoding.
package microprocessor_pkg;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JUMP  = 2'b11;

    // Jump with immediate -1: the PC holds in place.
    localparam logic [7:0] HALT_INSTR = 8'hC3;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        LOAD_ENTER  = 2'd1,
        LOAD_WAIT   = 2'd2,
        LOAD_COMMIT = 2'd3
    } load_state_t;

endpackage

// File: rtl/instruction_memory_strobe_debouncer.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and
// rising-edge detect producing a single-cycle press pulse.
module strobe_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic oscillator,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous button into the oscillator domain.
    always_ff @(posedge oscillator) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has held steady long enough;
    // any bounce back to the accepted level restarts the count.
    always_ff @(posedge oscillator) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == LAST) begin
                    r_cnt   <= '0;
                    r_level <= r_sync2;
                    r_press <= r_sync2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign press = r_press;

endmodule

// File: rtl/instruction_memory.sv
// Writable program store: keyed in from switches in load mode, serves
// instruction fetches in run mode. INSTRUCTION_MEMORY_DEFAULT_PROGRAM_EN
// makes reset preload a small demo program instead of all-HALT.
module instruction_memory
    import microprocessor_pkg::*;
#(
    parameter int DEPTH           = 32,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       oscillator,
    input  logic       reset,
    input  logic       load_mode,
    input  logic [7:0] data_switches,
    input  logic       write_strobe,
    input  logic [7:0] instruction_address,
    output logic [7:0] instruction,
    output logic [7:0] load_address,
    output logic       load_full,
    output logic       loading
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    load_state_t r_state;
    load_state_t w_next;
    logic        w_press;
    logic        w_addr_ok;
    logic [7:0]  r_mem [DEPTH];
    logic [7:0]  r_instruction;
    logic [7:0]  r_load_address;
    logic        r_load_full;

    strobe_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .oscillator(oscillator),
        .reset     (reset),
        .raw       (write_strobe),
        .press     (w_press)
    );

    // FSM state register.
    always_ff @(posedge oscillator) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next;
    end

    // Next state: leaving load mode always wins, except that a commit
    // already under way still completes its write this cycle.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            RUN:         w_next = load_mode ? LOAD_ENTER : RUN;
            LOAD_ENTER:  w_next = load_mode ? LOAD_WAIT : RUN;
            LOAD_WAIT: begin
                if (!load_mode)
                    w_next = RUN;
                else if (w_press && !r_load_full)
                    w_next = LOAD_COMMIT;
                else
                    w_next = LOAD_WAIT;
            end
            LOAD_COMMIT: w_next = load_mode ? LOAD_WAIT : RUN;
            default:     w_next = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        loading = (r_state != RUN);
    end

    // Write pointer and program store; reset refills every word.
    always_ff @(posedge oscillator) begin
        if (reset) begin
            r_load_address <= 8'd0;
            r_load_full    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= HALT_INSTR;
`ifdef INSTRUCTION_MEMORY_DEFAULT_PROGRAM_EN
            r_mem[0] <= 8'h45;
            r_mem[1] <= 8'h16;
            r_mem[2] <= 8'h88;
            r_mem[3] <= HALT_INSTR;
`endif
        end else if (r_state == LOAD_ENTER) begin
            r_load_address <= 8'd0;
            r_load_full    <= 1'b0;
        end else if (r_state == LOAD_COMMIT) begin
            r_mem[r_load_address[AW-1:0]] <= data_switches;
            r_load_address <= r_load_address + 8'd1;
            r_load_full    <= ({1'b0, r_load_address} + 9'd1) == DEPTH_W;
        end
    end

    assign w_addr_ok = ({1'b0, instruction_address} < DEPTH_W);

    // Registered fetch; the core sees HALT while the user is editing.
    always_ff @(posedge oscillator) begin
        if (reset)
            r_instruction <= HALT_INSTR;
        else if (r_state == RUN && w_addr_ok)
            r_instruction <= r_mem[instruction_address[AW-1:0]];
        else
            r_instruction <= HALT_INSTR;
    end

    assign instruction  = r_instruction;
    assign load_address = r_load_address;
    assign load_full    = r_load_full;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed self-checking bench for instruction_memory with a short
// debounce window so button presses take a handful of cycles.
module tb_instruction_memory;

    logic       oscillator = 1'b0;
    logic       reset;
    logic       load_mode;
    logic [7:0] data_switches;
    logic       write_strobe;
    logic [7:0] instruction_address;
    logic [7:0] instruction;
    logic [7:0] load_address;
    logic       load_full;
    logic       loading;

    int errors = 0;
    int checks = 0;

    instruction_memory #(
        .DEPTH          (32),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .oscillator         (oscillator),
        .reset              (reset),
        .load_mode          (load_mode),
        .data_switches      (data_switches),
        .write_strobe       (write_strobe),
        .instruction_address(instruction_address),
        .instruction        (instruction),
        .load_address       (load_address),
        .load_full          (load_full),
        .loading            (loading)
    );

    always #5 oscillator = ~oscillator;

    task automatic check(input string tag, input logic [7:0] got,
                         input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge oscillator);
    endtask

    // Clean press: held long enough to be accepted, then released long
    // enough for the release to be accepted too.
    task automatic strobe(input logic [7:0] d);
        data_switches = d;
        write_strobe  = 1'b1;
        cycles(10);
        write_strobe  = 1'b0;
        cycles(10);
    endtask

    task automatic read(input string tag, input logic [7:0] a,
                        input logic [7:0] exp);
        instruction_address = a;
        cycles(1);
        check(tag, instruction, exp);
    endtask

    function automatic logic [7:0] reset_word(input int a);
`ifdef INSTRUCTION_MEMORY_DEFAULT_PROGRAM_EN
        case (a)
            0:       return 8'h45;
            1:       return 8'h16;
            2:       return 8'h88;
            default: return 8'hC3;
        endcase
`else
        if (a >= 0) return 8'hC3;
        return 8'hC3;
`endif
    endfunction

    initial begin
        reset               = 1'b1;
        load_mode           = 1'b0;
        data_switches       = 8'h00;
        write_strobe        = 1'b0;
        instruction_address = 8'h00;
        cycles(2);
        reset = 1'b0;

        check("rst_load_address", load_address, 8'd0);
        check("rst_load_full", {7'd0, load_full}, 8'd0);
        check("rst_loading", {7'd0, loading}, 8'd0);
        check("rst_instruction", instruction, 8'hC3);

        read("run_addr0", 8'd0, reset_word(0));
        read("run_addr5", 8'd5, reset_word(5));
        read("run_addr31", 8'd31, 8'hC3);
        read("run_addr32", 8'd32, 8'hC3);
        read("run_addr200", 8'd200, 8'hC3);
`ifdef INSTRUCTION_MEMORY_DEFAULT_PROGRAM_EN
        read("demo_addr1", 8'd1, 8'h16);
        read("demo_addr2", 8'd2, 8'h88);
        read("demo_addr3", 8'd3, 8'hC3);
`endif

        // Program entry of three bytes.
        instruction_address = 8'd1;
        load_mode = 1'b1;
        cycles(2);
        check("load_loading", {7'd0, loading}, 8'd1);
        check("load_addr_start", load_address, 8'd0);
        strobe(8'h45);
        check("load_ptr1", load_address, 8'd1);
        check("load_instr_halt1", instruction, 8'hC3);
        strobe(8'h16);
        check("load_ptr2", load_address, 8'd2);
        strobe(8'h88);
        check("load_ptr3", load_address, 8'd3);
        check("load_instr_halt3", instruction, 8'hC3);
        check("load_not_full", {7'd0, load_full}, 8'd0);

        load_mode = 1'b0;
        cycles(2);
        check("run_loading", {7'd0, loading}, 8'd0);
        check("run_fetch1", instruction, 8'h16);
        read("run_fetch0", 8'd0, 8'h45);
        read("run_fetch2", 8'd2, 8'h88);
        read("run_fetch3", 8'd3, 8'hC3);

        // Bouncing button: only the final steady press is written.
        load_mode = 1'b1;
        cycles(2);
        check("bounce_ptr0", load_address, 8'd0);
        data_switches = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            write_strobe = ~write_strobe;
            cycles(2);
        end
        check("bounce_no_write", load_address, 8'd0);
        write_strobe = 1'b1;
        cycles(14);
        write_strobe = 1'b0;
        cycles(10);
        check("bounce_one_write", load_address, 8'd1);
        load_mode = 1'b0;
        cycles(2);
        read("bounce_word0", 8'd0, 8'hA5);
        read("bounce_kept1", 8'd1, 8'h16);

        // Fill the store, then one more press that must be dropped.
        load_mode = 1'b1;
        cycles(2);
        for (int i = 0; i < 31; i++) strobe(8'(i + 1));
        check("full_ptr31", load_address, 8'd31);
        check("full_not_yet", {7'd0, load_full}, 8'd0);
        strobe(8'h20);
        check("full_ptr32", load_address, 8'd32);
        check("full_set", {7'd0, load_full}, 8'd1);
        strobe(8'hEE);
        check("full_ptr_sat", load_address, 8'd32);
        check("full_still", {7'd0, load_full}, 8'd1);
        load_mode = 1'b0;
        cycles(2);
        read("full_word0", 8'd0, 8'h01);
        read("full_word31", 8'd31, 8'h20);
        read("full_word15", 8'd15, 8'h10);

        // Abort: load mode drops before the press is accepted.
        load_mode = 1'b1;
        cycles(2);
        strobe(8'h77);
        check("abort_ptr1", load_address, 8'd1);
        data_switches = 8'h99;
        write_strobe  = 1'b1;
        cycles(2);
        load_mode = 1'b0;
        cycles(10);
        write_strobe = 1'b0;
        cycles(10);
        check("abort_loading", {7'd0, loading}, 8'd0);
        check("abort_ptr", load_address, 8'd1);
        read("abort_word1", 8'd1, 8'h02);
        read("abort_word0", 8'd0, 8'h77);

        // Reset in the middle of a load.
        load_mode = 1'b1;
        cycles(2);
        strobe(8'hAA);
        strobe(8'hBB);
        strobe(8'hCC);
        check("midrst_ptr3", load_address, 8'd3);
        data_switches = 8'hDD;
        write_strobe  = 1'b1;
        cycles(3);
        reset     = 1'b1;
        load_mode = 1'b0;
        cycles(1);
        reset = 1'b0;
        check("midrst_ptr", load_address, 8'd0);
        check("midrst_loading", {7'd0, loading}, 8'd0);
        check("midrst_full", {7'd0, load_full}, 8'd0);
        cycles(10);
        write_strobe = 1'b0;
        cycles(10);
        for (int a = 0; a < 32; a++)
            read($sformatf("midrst_word%0d", a), 8'(a), reset_word(a));
        check("midrst_ptr_after", load_address, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
